hazard_fwd: RTL and testbench

HAZARD_FWD -- requirements
Module: hazard_fwd

---
 rtl/hazard_pkg.sv | 36 +++
 rtl/hazard_fwd_if.sv | 34 +++
 rtl/hazard_fwd_slot.sv | 25 ++
 rtl/hazard_fwd.sv | 78 +++++++
 tb/tb_hazard_fwd.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding unit: slot record,
// slot indices, forwarding-vector field layout and datapath widths.
package hazard_pkg;

  localparam int REG_W   = 3;
  localparam int DATA_W  = 16;

  localparam int N_SLOTS  = 3;
  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  localparam int FIELD_W = REG_W + 1;
  localparam int EX_OFF  = 0;
  localparam int MEM_OFF = 4;
  localparam int WB_OFF  = 8;
  localparam int VEC_W   = N_SLOTS * FIELD_W;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wsel;
    logic             is_load;
  } slot_t;

  // True when the decode instruction actually reads the register this slot writes.
  function automatic logic reads_reg(slot_t s,
                                     logic [REG_W-1:0] rs1, logic rs1_used,
                                     logic [REG_W-1:0] rs2, logic rs2_used);
    return (rs1_used && (rs1 == s.wsel)) || (rs2_used && (rs2 == s.wsel));
  endfunction

  function automatic logic [FIELD_W-1:0] fwd_field(logic v, logic [REG_W-1:0] sel);
    return {v, sel};
  endfunction

endpackage

// File: rtl/hazard_fwd_if.sv
// Decode/result/forwarding bundle between the pipeline datapath (master)
// and the hazard_fwd unit (slave).
interface hazard_fwd_if;
  import hazard_pkg::*;

  logic                  Dec_valid;
  logic                  Dec_regwrite;
  logic                  Dec_memread;
  logic [REG_W-1:0]      Dec_wsel;
  logic [REG_W-1:0]      Dec_rs1;
  logic [REG_W-1:0]      Dec_rs2;
  logic                  Dec_rs1_used;
  logic                  Dec_rs2_used;
  logic                  Flush;
  logic [DATA_W-1:0]     Ex_result;
  logic [DATA_W-1:0]     Mem_result;
  logic [DATA_W-1:0]     Wb_result;
  logic [VEC_W-1:0]      Forwarding_vector;
  logic [3*DATA_W-1:0]   Forwarding_data;
  logic                  Stall;

  modport master (
    output Dec_valid, Dec_regwrite, Dec_memread, Dec_wsel, Dec_rs1, Dec_rs2,
           Dec_rs1_used, Dec_rs2_used, Flush, Ex_result, Mem_result, Wb_result,
    input  Forwarding_vector, Forwarding_data, Stall
  );

  modport slave (
    input  Dec_valid, Dec_regwrite, Dec_memread, Dec_wsel, Dec_rs1, Dec_rs2,
           Dec_rs1_used, Dec_rs2_used, Flush, Ex_result, Mem_result, Wb_result,
    output Forwarding_vector, Forwarding_data, Stall
  );

endinterface

// File: rtl/hazard_fwd_slot.sv
// One pipeline-tracking slot: loads a record, or a bubble, each cycle;
// synchronous reset clears it.
module fwd_slot
  import hazard_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_bubble,
  input  slot_t i_d,
  output slot_t o_q
);

  slot_t r_q;

  // NOTE: state registers use non-blocking assignment so every slot samples
  // its neighbour's pre-edge value and the three slots shift in lockstep.
  always_ff @(posedge clk) begin
    if (rst)           r_q <= '0;
    else if (i_bubble) r_q <= '0;
    else               r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/hazard_fwd.sv
// Load-use hazard detection and forwarding-select generation for EX/MEM/WB.
// Define HAZARD_FWD_EN for forwarding; otherwise a full interlock is built.
module hazard_fwd
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  hazard_fwd_if.slave  bus
);

  slot_t w_slot [N_SLOTS];
  slot_t w_dec;
  logic  w_hazard;
  logic  w_stall;
  logic  w_unused;

  assign w_dec = '{valid:   bus.Dec_valid & bus.Dec_regwrite,
                   wsel:    bus.Dec_wsel,
                   is_load: bus.Dec_memread};

  fwd_slot u_ex (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (w_stall | bus.Flush),
    .i_d      (w_dec),
    .o_q      (w_slot[SLOT_EX])
  );

  fwd_slot u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_d      (w_slot[SLOT_EX]),
    .o_q      (w_slot[SLOT_MEM])
  );

  fwd_slot u_wb (
    .clk      (clk),
    .rst      (rst),
    .i_bubble (1'b0),
    .i_d      (w_slot[SLOT_MEM]),
    .o_q      (w_slot[SLOT_WB])
  );

`ifdef HAZARD_FWD_EN
  // Only a load still in EX lacks data; MEM/WB loads forward from their results.
  assign w_hazard = w_slot[SLOT_EX].valid & w_slot[SLOT_EX].is_load & bus.Dec_valid &
                    reads_reg(w_slot[SLOT_EX], bus.Dec_rs1, bus.Dec_rs1_used,
                              bus.Dec_rs2, bus.Dec_rs2_used);

  assign bus.Forwarding_vector[WB_OFF  +: FIELD_W] =
    fwd_field(w_slot[SLOT_WB].valid, w_slot[SLOT_WB].wsel);
  assign bus.Forwarding_vector[MEM_OFF +: FIELD_W] =
    fwd_field(w_slot[SLOT_MEM].valid, w_slot[SLOT_MEM].wsel);
  assign bus.Forwarding_vector[EX_OFF  +: FIELD_W] =
    fwd_field(w_slot[SLOT_EX].valid & ~w_slot[SLOT_EX].is_load, w_slot[SLOT_EX].wsel);
`else
  logic [N_SLOTS-1:0] w_hit;

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_hit
    assign w_hit[i] = w_slot[i].valid &
                      reads_reg(w_slot[i], bus.Dec_rs1, bus.Dec_rs1_used,
                                bus.Dec_rs2, bus.Dec_rs2_used);
  end

  // Without forwarding, any in-flight producer blocks the reader until it retires.
  assign w_hazard = bus.Dec_valid & (|w_hit);
  assign bus.Forwarding_vector = '0;
`endif

  assign w_stall         = w_hazard & ~bus.Flush;
  assign bus.Stall       = w_stall;
  assign bus.Forwarding_data = {bus.Wb_result, bus.Mem_result, bus.Ex_result};

  assign w_unused = ^{w_slot[SLOT_EX].is_load, w_slot[SLOT_MEM].is_load,
                      w_slot[SLOT_WB].is_load};

endmodule

// File: tb/tb_hazard_fwd.sv
// Self-checking bench for hazard_fwd: directed table, corner sequences and a
// randomized run against a pipeline reference model (both build modes).
module tb_hazard_fwd;
  import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_fwd_if bus();

  hazard_fwd u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference pipeline: entry 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit       v;
    bit [2:0] sel;
    bit       ld;
  } mrec_t;
  mrec_t pipe [3];

  typedef struct {
    bit        dv, rw, mr;
    bit [2:0]  wsel, rs1;
    bit        u1;
    bit [2:0]  rs2;
    bit        u2, fl;
    bit        st_fwd;
    bit [11:0] vec_fwd;
    bit        st_il;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit reads(input bit [2:0] r);
    return (bus.Dec_rs1_used && bus.Dec_rs1 == r) || (bus.Dec_rs2_used && bus.Dec_rs2 == r);
  endfunction

  function automatic bit m_stall();
    bit hit = 1'b0;
    if (!bus.Dec_valid || bus.Flush) return 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pipe[i].v && reads(pipe[i].sel)) begin
        if (!FWD) hit = 1'b1;
        else if (i == 0 && pipe[i].ld) hit = 1'b1;
      end
    end
    return hit;
  endfunction

  function automatic logic [11:0] m_vec();
    logic [11:0] vec = '0;
    if (!FWD) return vec;
    for (int i = 0; i < 3; i++)
      vec[4*i +: 4] = {pipe[i].v && !(i == 0 && pipe[i].ld), pipe[i].sel};
    return vec;
  endfunction

  task automatic model_edge();
    bit s;
    if (rst) begin
      for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, sel: 3'd0, ld: 1'b0};
    end else begin
      s = m_stall();
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (s || bus.Flush) pipe[0] = '{v: 1'b0, sel: 3'd0, ld: 1'b0};
      else pipe[0] = '{v: bus.Dec_valid && bus.Dec_regwrite, sel: bus.Dec_wsel, ld: bus.Dec_memread};
    end
  endtask

  task automatic drive(input bit dv, input bit rw, input bit mr, input bit [2:0] wsel,
                       input bit [2:0] rs1, input bit u1, input bit [2:0] rs2, input bit u2,
                       input bit fl);
    bus.Dec_valid    = dv;
    bus.Dec_regwrite = rw;
    bus.Dec_memread  = mr;
    bus.Dec_wsel     = wsel;
    bus.Dec_rs1      = rs1;
    bus.Dec_rs1_used = u1;
    bus.Dec_rs2      = rs2;
    bus.Dec_rs2_used = u2;
    bus.Flush        = fl;
    bus.Ex_result    = 16'($urandom);
    bus.Mem_result   = 16'($urandom);
    bus.Wb_result    = 16'($urandom);
  endtask

  task automatic check_data(input string tag);
    check({tag, "_data"}, 64'(bus.Forwarding_data),
          64'({bus.Wb_result, bus.Mem_result, bus.Ex_result}));
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    check({tag, "_stall"}, 64'(bus.Stall), 64'(m_stall()));
    check({tag, "_vec"}, 64'(bus.Forwarding_vector), 64'(m_vec()));
    check_data(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); model_edge();
    @(posedge clk); model_edge();
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_stall", 64'(bus.Stall), 64'd0);
    check("reset_vec", 64'(bus.Forwarding_vector), 64'd0);
    @(posedge clk); model_edge();
    #1;
  endtask

  initial begin
    //          dv rw mr ws r1 u1 r2 u2 fl  st_f vec_f     st_il
    tbl[0]  = '{1, 1, 0, 3, 0, 0, 0, 0, 0,  0,   12'h000,  0};
    tbl[1]  = '{1, 1, 0, 4, 3, 1, 0, 0, 0,  0,   12'h00B,  1};
    tbl[2]  = '{1, 1, 0, 4, 3, 1, 0, 0, 0,  0,   12'h0BC,  1};
    tbl[3]  = '{1, 1, 0, 4, 3, 1, 0, 0, 0,  0,   12'hBCC,  1};
    tbl[4]  = '{1, 1, 0, 4, 3, 1, 0, 0, 0,  0,   12'hCCC,  0};
    tbl[5]  = '{1, 1, 1, 2, 0, 0, 0, 0, 0,  0,   12'hCCC,  0};
    tbl[6]  = '{1, 1, 0, 5, 2, 1, 0, 0, 0,  1,   12'hCC2,  1};
    tbl[7]  = '{1, 1, 0, 5, 2, 1, 0, 0, 1,  0,   12'hCA0,  0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   12'hA00,  0};
    tbl[9]  = '{1, 1, 0, 1, 0, 0, 0, 0, 0,  0,   12'h000,  0};
    tbl[10] = '{1, 1, 0, 1, 0, 0, 0, 0, 0,  0,   12'h009,  0};
    tbl[11] = '{0, 0, 0, 0, 1, 1, 0, 0, 0,  0,   12'h099,  0};
    tbl[12] = '{1, 1, 0, 7, 1, 0, 1, 1, 0,  0,   12'h990,  1};

    do_reset();

    for (int k = 0; k < 13; k++) begin
      vec_t t;
      t = tbl[k];
      drive(t.dv, t.rw, t.mr, t.wsel, t.rs1, t.u1, t.rs2, t.u2, t.fl);
      @(negedge clk);
      check($sformatf("tbl%0d_stall", k), 64'(bus.Stall), 64'(FWD ? t.st_fwd : t.st_il));
      check($sformatf("tbl%0d_vec", k), 64'(bus.Forwarding_vector),
            64'(FWD ? t.vec_fwd : 12'h000));
      check_data($sformatf("tbl%0d", k));
      @(posedge clk); model_edge();
      #1;
    end

    // Load-use pair with a same-cycle flush: no stall, and the user never enters EX.
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
    tick("flush_ld");
    drive(1, 1, 0, 5, 2, 1, 0, 0, 1);
    @(negedge clk);
    check("flush_use_stall", 64'(bus.Stall), 64'd0);
    @(posedge clk); model_edge();
    #1;
    drive(1, 1, 0, 6, 5, 1, 0, 0, 0);
    @(negedge clk);
    check("flush_next_vec", 64'(bus.Forwarding_vector), 64'(FWD ? 12'h0A0 : 12'h000));
    check("flush_next_stall", 64'(bus.Stall), 64'd0);
    @(posedge clk); model_edge();
    #1;

    // Reset arriving while a load-use stall is in progress.
    do_reset();
    drive(1, 1, 1, 2, 0, 0, 0, 0, 0);
    tick("rst_ld");
    drive(1, 1, 0, 5, 2, 1, 0, 0, 0);
    @(negedge clk);
    check("rst_pre_stall", 64'(bus.Stall), 64'd1);
    rst = 1'b1;
    @(posedge clk); model_edge();
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_post_stall", 64'(bus.Stall), 64'd0);
    check("rst_post_vec", 64'(bus.Forwarding_vector), 64'd0);
    @(posedge clk); model_edge();
    #1;

    // Randomized traffic over a small register set to provoke frequent matches.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0),
            bit'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            3'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 15) == 0));
      tick("rnd");
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
